// File: rtl/sr_ff_bank.sv
// Bank of WIDTH set/reset flags with S=R=1 resolution, edge pulses, sticky conflicts and a conflict counter.
// Latency: 1 cycle from sampled inputs to every output. All outputs are registered.
// Backpressure: none. Inputs are consumed every cycle, and en=0 freezes q and suppresses new events.
module sr_ff_bank #(
  parameter int unsigned      WIDTH = 8,
  parameter int unsigned      MODE  = 1,
  parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b0}},
  parameter int unsigned      CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] conflict_clr,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_rise,
  output logic [WIDTH-1:0] q_fall,
  output logic [WIDTH-1:0] conflict,
  output logic [CNT_W-1:0] conflict_cnt
);

  // MODE values outside 0..3 decode to none of these flags, so they behave as hold.
  localparam bit M_SET = (MODE == 32'd1);
  localparam bit M_RST = (MODE == 32'd2);
  localparam bit M_TOG = (MODE == 32'd3);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] conf_bits;      // channels requesting set and reset together this cycle
  logic [WIDTH-1:0] conf_res;       // value taken by a channel in conflict
  logic [WIDTH-1:0] q_n;            // next flip-flop state
  logic             conflict_cycle; // enabled cycle with at least one conflicting channel

  // Resolve the next state per channel; en=0 leaves every channel unchanged.
  always_comb begin
    conf_bits = s & r;
    if (M_SET) begin
      conf_res = {WIDTH{1'b1}};
    end else if (M_RST) begin
      conf_res = {WIDTH{1'b0}};
    end else if (M_TOG) begin
      conf_res = ~q;
    end else begin
      conf_res = q;
    end
    q_n = q;
    if (en) begin
      q_n = (q & ~s & ~r) | (s & ~r) | (conf_bits & conf_res);
    end
    conflict_cycle = en & (|conf_bits);
  end

  // State and edge pulses. Because q_n equals q when en=0, no pulse can fire while disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      q      <= INIT;
      q_rise <= {WIDTH{1'b0}};
      q_fall <= {WIDTH{1'b0}};
    end else begin
      q      <= q_n;
      q_rise <= ~q & q_n;
      q_fall <= q & ~q_n;
    end
  end

  // Sticky conflict flags. A new event wins over a same-cycle clear, so no event is lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      conflict <= {WIDTH{1'b0}};
    end else begin
      conflict <= (conflict & ~conflict_clr) | ({WIDTH{en}} & conf_bits);
    end
  end

  // Saturating count of conflict cycles. A clear that coincides with a conflict restarts the count at 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      conflict_cnt <= {CNT_W{1'b0}};
    end else if (cnt_clr) begin
      conflict_cnt <= conflict_cycle ? CNT_ONE : {CNT_W{1'b0}};
    end else if (conflict_cycle && (conflict_cnt != CNT_MAX)) begin
      conflict_cnt <= conflict_cnt + CNT_ONE;
    end
  end

endmodule

// File: doc/sr_ff_bank.md
# sr_ff_bank

Parametrised bank of WIDTH independent synchronous set/reset flip-flops with a selectable S=R=1 resolution mode. The bank adds registered edge pulses, per-channel sticky conflict flags and a saturating conflict-cycle counter. It replaces single-bit SR storage wherever control and status logic needs many set/clear flags with defined behaviour in every input combination. No high-impedance state is ever driven.

## Interface

- WIDTH, 8: number of channels (≥1).
- MODE, 1: S=R=1 resolution, one of:
  - 0: hold
  - 1: set-dominant
  - 2: reset-dominant
  - 3: toggle
- INIT, {WIDTH{1'b0}}: value loaded into q by reset.
- CNT_W, 8: conflict counter width (≥1).

Ports:

- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high; clock clk.
- en  in  1  bank update enable.
- s  in  WIDTH  per-channel set request.
- r  in  WIDTH  per-channel reset request.
- conflict_clr  in  WIDTH  per-channel clear of the sticky conflict flag.
- cnt_clr  in  1  clear of the conflict counter.
- q  out  WIDTH  flip-flop state.
- q_rise  out  WIDTH  one-cycle pulse on a q 0→1 change.
- q_fall  out  WIDTH  one-cycle pulse on a q 1→0 change.
- conflict  out  WIDTH  sticky flag: channel saw s=r=1 while en=1.
- conflict_cnt  out  CNT_W  count of enabled cycles with any s&r bit set; saturating.

## Operation

- Per channel i, when en=1, the next state q_n is:
  - {s,r}=00: q.
  - {s,r}=01: 0.
  - {s,r}=10: 1.
  - {s,r}=11, by MODE: 0 → q; 1 → 1; 2 → 0; 3 → ~q.
- en=0: q holds. q_rise and q_fall are 0. No conflict is flagged and the counter does not increment. conflict_clr and cnt_clr still take effect.
- Edge pulses are registered:
  - q_rise <= en & ~q & q_n
  - q_fall <= en & q & ~q_n
  - A pulse is therefore high exactly in the first cycle that q shows the new value.
- Sticky flag: conflict[i] <= (conflict[i] & ~conflict_clr[i]) | (en & s[i] & r[i]).
  - A new event in the same cycle as a clear leaves the flag set, so no event is lost.
- Counter: a cycle is a conflict cycle when en=1 and |(s&r)=1.
  - cnt_clr=1 loads the counter with 1 if that cycle is a conflict cycle, otherwise 0.
  - Otherwise the counter increments by 1 on a conflict cycle.
  - It saturates at 2^CNT_W−1 and never wraps.
  - The count is per cycle, not per channel: 3 channels in conflict in one cycle add 1.
- MODE is static. Values outside 0..3 behave as 0 (hold).
- Channels are fully independent. There is no cross-channel priority.

## Timing

- reset=1 at a clock edge has priority over en, s, r and both clears. After that edge:
  - q=INIT
  - q_rise=0, q_fall=0
  - conflict=0
  - conflict_cnt=0
- Reset is synchronous. Asserting it mid-operation discards pending pulses, and inputs sampled in that cycle have no effect.
- Inputs are sampled at edge k. q, the pulses, conflict and conflict_cnt reflect them after edge k, so latency is 1 cycle.
- There is no combinational path from any input to any output. All outputs are registered.
- In toggle mode, continuous s=r=1 toggles q every enabled cycle, and q_rise/q_fall alternate every cycle.
- In the first cycle after reset deasserts, q=INIT and no pulse is produced by the reset itself.

## Test plan

- Reset and basic SR (WIDTH=4, INIT=4'b1010, MODE=1):
  - After reset: q=1010, conflict_cnt=0, all pulses 0.
  - s=0001,r=0000 → next cycle q=1011, q_rise=0001.
  - r=0010 → q=1001, q_fall=0010.
- Conflict modes (channel 0, q=0, s=r=1 held 3 cycles):
  - MODE=0: q stays 0.
  - MODE=1: q=1 with one q_rise pulse.
  - MODE=2: q stays 0.
  - MODE=3: q goes 1,0,1 with rise/fall/rise pulses.
  - Every mode: conflict[0]=1 and conflict_cnt=3.
- Enable gating: en=0 with s=1111,r=0000 for 2 cycles → q unchanged, no pulses. Raise en → q=1111 one cycle later.
- Sticky clear race:
  - conflict_clr[2]=1 in the same cycle as s[2]=r[2]=1 → conflict[2] stays 1.
  - Clear alone the next cycle → conflict[2]=0.
  - cnt_clr with a conflict in the same cycle → conflict_cnt=1.
- Saturation (CNT_W=2): 5 consecutive conflict cycles → conflict_cnt reads 1,2,3,3,3.
- Reset mid-operation: MODE=3, s=r=1111 running, reset=1 for one cycle → q=INIT, conflict=0, cnt=0, no pulses that cycle. Toggling resumes from INIT the following cycle.
